seg7_scan_driver: RTL and testbench

//  Display-side partner of the ring-counter digit scanner. Generates the

---
 rtl/seg7_scan_driver.sv | 166 ++++++++++++++++
 tb/tb_seg7_scan_driver.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_driver.sv
// Multiplexed 7-segment display driver: scan-step prescaler, double-buffered
// frame (pending/active) committed at scan wrap, registered active-low drives.
module seg7_scan_driver #(
   parameter int unsigned DIGITS   = 4,
   parameter int unsigned CLK_DIV  = 50000,
   parameter int unsigned BLANK_LZ = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [4*DIGITS-1:0]   data_in,
   input  logic [DIGITS-1:0]     dp_in,
   input  logic                  load,
   output logic                  load_ready,
   input  logic [DIGITS-1:0]     an_in,
   output logic                  scan_tick,
   output logic [6:0]            seg_out,
   output logic                  dp_out,
   output logic [DIGITS-1:0]     an_out
);

   localparam int unsigned DATA_W = 4 * DIGITS;
   localparam int unsigned CNT_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int unsigned ZC_W   = $clog2(DIGITS + 1);

   // Hex nibble to active-low {g,f,e,d,c,b,a}
   function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
      logic [6:0] s;
      s = 7'h7F;
      case (nib)
         4'h0: s = 7'h40;
         4'h1: s = 7'h79;
         4'h2: s = 7'h24;
         4'h3: s = 7'h30;
         4'h4: s = 7'h19;
         4'h5: s = 7'h12;
         4'h6: s = 7'h02;
         4'h7: s = 7'h78;
         4'h8: s = 7'h00;
         4'h9: s = 7'h10;
         4'hA: s = 7'h08;
         4'hB: s = 7'h03;
         4'hC: s = 7'h46;
         4'hD: s = 7'h21;
         4'hE: s = 7'h06;
         4'hF: s = 7'h0E;
      endcase
      return s;
   endfunction

   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              tick_q, tick_d;
   logic [DATA_W-1:0] pend_q, pend_d;
   logic [DIGITS-1:0] pend_dp_q, pend_dp_d;
   logic [DATA_W-1:0] act_q, act_d;
   logic [DIGITS-1:0] act_dp_q, act_dp_d;
   logic              ready_q, ready_d;
   logic [6:0]        seg_q, seg_d;
   logic              dp_q, dp_d;
   logic [DIGITS-1:0] an_q, an_d;

   logic              commit_c;
   logic              transfer_c;
   logic [DIGITS-1:0] upper_zero;
   logic [ZC_W-1:0]   zero_cnt;
   logic [3:0]        sel_nib;
   logic              sel_dp;
   logic              sel_blank;
   logic              run_zero;

   // Prescaler: scan_tick is high the cycle after the count hits CLK_DIV-1
   always_comb begin
      cnt_d  = cnt_q + CNT_W'(1);
      tick_d = 1'b0;
      if (cnt_q == CNT_W'(CLK_DIV - 1)) begin
         cnt_d  = '0;
         tick_d = 1'b1;
      end
   end

   // Pending is full exactly when load_ready is low, so commit and transfer are exclusive
   assign commit_c   = tick_q & ~an_in[DIGITS-1] & ~ready_q;
   assign transfer_c = load & ready_q;

   always_comb begin
      pend_d    = pend_q;
      pend_dp_d = pend_dp_q;
      act_d     = act_q;
      act_dp_d  = act_dp_q;
      ready_d   = ready_q;
      if (commit_c) begin
         act_d    = pend_q;
         act_dp_d = pend_dp_q;
         ready_d  = 1'b1;
      end else if (transfer_c) begin
         pend_d    = data_in;
         pend_dp_d = dp_in;
         ready_d   = 1'b0;
      end
   end

   // Digit select, leading-zero blanking and decode for the next output register
   always_comb begin
      upper_zero = '0;
      zero_cnt   = '0;
      sel_nib    = 4'h0;
      sel_dp     = 1'b0;
      sel_blank  = 1'b0;
      run_zero   = 1'b1;
      seg_d      = 7'h7F;
      dp_d       = 1'b1;
      an_d       = '1;

      for (int i = int'(DIGITS) - 1; i >= 0; i--) begin
         run_zero      = run_zero & (act_q[4*i +: 4] == 4'h0);
         upper_zero[i] = run_zero;
      end

      for (int unsigned i = 0; i < DIGITS; i++) begin
         if (!an_in[i]) begin
            zero_cnt  = zero_cnt + ZC_W'(1);
            sel_nib   = act_q[4*i +: 4];
            sel_dp    = act_dp_q[i];
            sel_blank = (BLANK_LZ != 0) && (i != 0) && upper_zero[i];
         end
      end

      if (zero_cnt == ZC_W'(1)) begin
         seg_d = sel_blank ? 7'h7F : hex_to_seg(sel_nib);
         dp_d  = ~sel_dp;
         an_d  = an_in;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q     <= '0;
         tick_q    <= 1'b0;
         pend_q    <= '0;
         pend_dp_q <= '0;
         act_q     <= '0;
         act_dp_q  <= '0;
         ready_q   <= 1'b1;
         seg_q     <= 7'h7F;
         dp_q      <= 1'b1;
         an_q      <= '1;
      end else begin
         cnt_q     <= cnt_d;
         tick_q    <= tick_d;
         pend_q    <= pend_d;
         pend_dp_q <= pend_dp_d;
         act_q     <= act_d;
         act_dp_q  <= act_dp_d;
         ready_q   <= ready_d;
         seg_q     <= seg_d;
         dp_q      <= dp_d;
         an_q      <= an_d;
      end
   end

   assign scan_tick  = tick_q;
   assign load_ready = ready_q;
   assign seg_out    = seg_q;
   assign dp_out     = dp_q;
   assign an_out     = an_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver: bench-side ring counter, queue-based reference
// model of the frame buffers, scoreboard compared on the falling edge.
module tb_seg7_scan_driver;

   localparam int unsigned DIGITS  = 4;
   localparam int unsigned CLK_DIV = 4;
   localparam int unsigned BLANK_LZ = 1;

   logic        clk;
   logic        rst;
   logic [15:0] data_in;
   logic [3:0]  dp_in;
   logic        load;
   logic        load_ready;
   logic [3:0]  an_in;
   logic        scan_tick;
   logic [6:0]  seg_out;
   logic        dp_out;
   logic [3:0]  an_out;

   seg7_scan_driver #(
      .DIGITS(DIGITS), .CLK_DIV(CLK_DIV), .BLANK_LZ(BLANK_LZ)
   ) dut (
      .clk(clk), .rst(rst), .data_in(data_in), .dp_in(dp_in), .load(load),
      .load_ready(load_ready), .an_in(an_in), .scan_tick(scan_tick),
      .seg_out(seg_out), .dp_out(dp_out), .an_out(an_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // External ring counter stepped by the driver's scan pulse
   logic [3:0] ring;
   logic       force_en;
   logic [3:0] force_val;
   always @(posedge clk) begin
      if (rst) ring <= 4'b1110;
      else if (scan_tick) ring <= {ring[2:0], ring[3]};
   end
   assign an_in = force_en ? force_val : ring;

   typedef struct {
      logic [6:0] seg;
      logic       dp;
      logic [3:0] an;
      logic       ready;
      logic       tick;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   logic [6:0] seg_tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

   // Reference model state
   int          n_cyc;
   int          act_nib [4];
   bit          act_dp  [4];
   logic [15:0] pend_data[$];
   logic [3:0]  pend_dp[$];

   function automatic void expect_disp(input logic [3:0] an, output logic [6:0] seg,
                                       output logic dp, output logic [3:0] an_o);
      int  zeros;
      int  k;
      bit  blank;
      zeros = 0;
      k = 0;
      for (int i = 0; i < 4; i++) if (an[i] == 1'b0) begin zeros++; k = i; end
      if (zeros != 1) begin
         seg = 7'h7F; dp = 1'b1; an_o = 4'hF;
      end else begin
         blank = (BLANK_LZ != 0) && (k > 0);
         for (int j = k; j < 4; j++) if (act_nib[j] != 0) blank = 1'b0;
         seg  = blank ? 7'h7F : seg_tbl[act_nib[k]];
         dp   = !act_dp[k];
         an_o = an;
      end
   endfunction

   always @(posedge clk) begin : model
      exp_t        e;
      bit          tick_now;
      bit          commit;
      bit          transfer;
      logic [15:0] d;
      logic [3:0]  p;
      if (rst) begin
         n_cyc = 0;
         for (int i = 0; i < 4; i++) begin act_nib[i] = 0; act_dp[i] = 1'b0; end
         pend_data.delete();
         pend_dp.delete();
         e.seg = 7'h7F; e.dp = 1'b1; e.an = 4'hF; e.ready = 1'b1; e.tick = 1'b0;
      end else begin
         tick_now = (n_cyc > 0) && (n_cyc % CLK_DIV == 0);
         expect_disp(an_in, e.seg, e.dp, e.an);
         commit   = tick_now && !an_in[3] && (pend_data.size() > 0);
         transfer = load && (pend_data.size() == 0);
         if (commit) begin
            d = pend_data.pop_front();
            p = pend_dp.pop_front();
            for (int i = 0; i < 4; i++) begin
               act_nib[i] = int'((d >> (4 * i)) & 16'hF);
               act_dp[i]  = p[i];
            end
         end else if (transfer) begin
            pend_data.push_back(data_in);
            pend_dp.push_back(dp_in);
         end
         n_cyc++;
         e.ready = (pend_data.size() == 0);
         e.tick  = (n_cyc % CLK_DIV == 0);
      end
      exp_q.push_back(e);
   end

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin : monitor
      exp_t e;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         chk("seg_out",    16'(seg_out),    16'(e.seg));
         chk("dp_out",     16'(dp_out),     16'(e.dp));
         chk("an_out",     16'(an_out),     16'(e.an));
         chk("load_ready", 16'(load_ready), 16'(e.ready));
         chk("scan_tick",  16'(scan_tick),  16'(e.tick));
      end
   end

   // Source side: hold the word until the driver accepts it
   task automatic do_load(input logic [15:0] d, input logic [3:0] p);
      data_in = d;
      dp_in   = p;
      load    = 1'b1;
      for (int c = 0; c < 200; c++) begin
         if (load_ready) begin
            @(negedge clk);
            load = 1'b0;
            return;
         end
         @(negedge clk);
      end
      load = 1'b0;
      checks++;
      errors++;
      $display("FAIL load_timeout actual=no_accept expected=accept at %0t", $time);
   endtask

   task automatic idle(input int c);
      repeat (c) @(negedge clk);
   endtask

   initial begin
      logic [15:0] d;
      rst = 1'b1; load = 1'b0; data_in = '0; dp_in = '0;
      force_en = 1'b0; force_val = 4'hF;
      idle(3);
      rst = 1'b0;
      idle(12);

      do_load(16'h12AF, 4'b0001);
      idle(40);

      do_load(16'h0005, 4'b0000);
      idle(40);
      do_load(16'h0000, 4'b0000);
      idle(40);

      do_load(16'h3C4D, 4'b1000);
      do_load(16'hE0B7, 4'b0110);
      idle(40);

      force_en = 1'b1; force_val = 4'b1111;
      idle(3);
      force_val = 4'b1100;
      idle(3);
      force_en = 1'b0;
      idle(4);

      do_load(16'h9876, 4'hF);
      idle(2);
      rst = 1'b1;
      idle(2);
      rst = 1'b0;
      idle(20);

      for (int it = 0; it < 30; it++) begin
         d = 16'($urandom);
         d = d >> (4 * $urandom_range(0, 3));
         do_load(d, 4'($urandom));
         if ($urandom_range(0, 5) == 0) begin
            force_en  = 1'b1;
            force_val = 4'($urandom);
            idle($urandom_range(1, 4));
            force_en  = 1'b0;
         end
         idle($urandom_range(0, 20));
      end
      idle(40);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
